// File: rtl/wait_event_pkg.sv
// Shared types for the wait-event monitor: evaluation modes and FSM states.
package wait_event_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE   = 2'b00,
    WAIT_FALL   = 2'b01,
    WAIT_MATCH  = 2'b10,
    WAIT_CHANGE = 2'b11
  } wait_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARM  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } wait_state_e;

  localparam int ELAPSED_W = 32;

endpackage

// File: rtl/wait_event_cond.sv
// Channel select, masking, previous-value register and per-mode occurrence decode.
module wait_event_cond
  import wait_event_pkg::*;
#(
  parameter int WAIT_SIZE  = 5,
  parameter int WAIT_WIDTH = 8,
  localparam int SEL_W     = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cap_en,
  input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] i_wait,
  input  logic [SEL_W-1:0]                sel,
  input  wait_mode_e                      mode,
  input  logic [WAIT_WIDTH-1:0]           mask,
  input  logic [WAIT_WIDTH-1:0]           match_val,
  output logic                            occ
);

  logic [WAIT_WIDTH-1:0] ch;
  logic [WAIT_WIDTH-1:0] m;
  logic [WAIT_WIDTH-1:0] prev_d;
  logic [WAIT_WIDTH-1:0] prev_q;

  always_comb begin
    ch = '0;
    for (int n = 0; n < WAIT_SIZE; n++) begin
      if (sel == SEL_W'(n)) ch = i_wait[n*WAIT_WIDTH +: WAIT_WIDTH];
    end
  end

  always_comb begin
    m      = ch & mask;
    prev_d = cap_en ? m : prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= prev_d;
  end

  always_comb begin
    occ = 1'b0;
    case (mode)
      WAIT_RISE:   occ = !(|prev_q) && (|m);
      WAIT_FALL:   occ = (|prev_q) && !(|m);
      WAIT_MATCH:  occ = (m == (match_val & mask));
      WAIT_CHANGE: occ = (m != prev_q);
      default:     occ = 1'b0;
    endcase
  end

endmodule

// File: rtl/wait_event_mon.sv
// Arms a wait on one channel, counts occurrences of the selected event and
// reports completion or timeout with a one-cycle done pulse.
//
// state   | meaning
// IDLE    | no wait armed; accepts start or flags a bad channel index
// ARM     | config held, reference value captured, no evaluation
// WAIT    | evaluating occurrences and elapsed cycles every clock
// DONE    | one-cycle end-of-wait, results latched
module wait_event_mon
  import wait_event_pkg::*;
#(
  parameter int WAIT_SIZE  = 5,
  parameter int WAIT_WIDTH = 8,
  parameter int OCC_WIDTH  = 8,
  localparam int SEL_W     = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic                            i_abort,
  input  logic [SEL_W-1:0]                i_sel,
  input  logic [1:0]                      i_mode,
  input  logic [WAIT_WIDTH-1:0]           i_mask,
  input  logic [WAIT_WIDTH-1:0]           i_match_val,
  input  logic [OCC_WIDTH-1:0]            i_occ_nb,
  input  logic [ELAPSED_W-1:0]            i_max_timeout,
  input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] i_wait,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_timeout,
  output logic                            o_cfg_err,
  output logic [ELAPSED_W-1:0]            o_elapsed,
  output logic [OCC_WIDTH-1:0]            o_occ_cnt
);

  wait_state_e state_q, state_d;

  logic [SEL_W-1:0]      sel_q, sel_d;
  wait_mode_e            mode_q, mode_d;
  logic [WAIT_WIDTH-1:0] mask_q, mask_d;
  logic [WAIT_WIDTH-1:0] match_q, match_d;
  logic [OCC_WIDTH-1:0]  occ_nb_q, occ_nb_d;
  logic [ELAPSED_W-1:0]  max_to_q, max_to_d;

  logic [ELAPSED_W-1:0]  elapsed_q, elapsed_d, elapsed_inc;
  logic [OCC_WIDTH-1:0]  occ_q, occ_d, occ_inc, occ_next, occ_nb_eff;

  logic                  o_busy_q, o_busy_d;
  logic                  o_done_q, o_done_d;
  logic                  o_timeout_q, o_timeout_d;
  logic                  o_cfg_err_q, o_cfg_err_d;
  logic [ELAPSED_W-1:0]  o_elapsed_q, o_elapsed_d;
  logic [OCC_WIDTH-1:0]  o_occ_cnt_q, o_occ_cnt_d;

  logic occ_hit, sel_ok, cap_en, hit_goal, hit_limit;

  wait_event_cond #(
    .WAIT_SIZE (WAIT_SIZE),
    .WAIT_WIDTH(WAIT_WIDTH)
  ) u_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap_en   (cap_en),
    .i_wait   (i_wait),
    .sel      (sel_q),
    .mode     (mode_q),
    .mask     (mask_q),
    .match_val(match_q),
    .occ      (occ_hit)
  );

  // Saturating counters; match mode restarts its run on any miss.
  always_comb begin
    sel_ok      = 32'(i_sel) < 32'(WAIT_SIZE);
    occ_nb_eff  = (occ_nb_q == '0) ? OCC_WIDTH'(1) : occ_nb_q;
    elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + 32'd1;
    occ_inc     = (&occ_q) ? occ_q : occ_q + OCC_WIDTH'(1);
    if (mode_q == WAIT_MATCH) occ_next = occ_hit ? occ_inc : '0;
    else                      occ_next = occ_hit ? occ_inc : occ_q;
    hit_goal    = (occ_next >= occ_nb_eff);
    hit_limit   = (max_to_q != '0) && (elapsed_inc >= max_to_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start && sel_ok) state_d = ST_ARM;
      ST_ARM:  state_d = i_abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (i_abort)                    state_d = ST_IDLE;
        else if (hit_goal || hit_limit) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d       = sel_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    match_d     = match_q;
    occ_nb_d    = occ_nb_q;
    max_to_d    = max_to_q;
    elapsed_d   = elapsed_q;
    occ_d       = occ_q;
    cap_en      = 1'b0;
    o_busy_d    = (state_d == ST_ARM) || (state_d == ST_WAIT);
    o_done_d    = (state_d == ST_DONE);
    o_timeout_d = 1'b0;
    o_cfg_err_d = (state_q == ST_IDLE) && i_start && !sel_ok;
    o_elapsed_d = o_elapsed_q;
    o_occ_cnt_d = o_occ_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start && sel_ok) begin
          sel_d     = i_sel;
          mode_d    = wait_mode_e'(i_mode);
          mask_d    = i_mask;
          match_d   = i_match_val;
          occ_nb_d  = i_occ_nb;
          max_to_d  = i_max_timeout;
          elapsed_d = '0;
          occ_d     = '0;
        end
      end
      ST_ARM: cap_en = 1'b1;
      ST_WAIT: begin
        if (!i_abort) begin
          cap_en    = 1'b1;
          elapsed_d = elapsed_inc;
          occ_d     = occ_next;
          if (state_d == ST_DONE) begin
            o_timeout_d = !hit_goal;
            o_elapsed_d = elapsed_inc;
            o_occ_cnt_d = occ_next;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      mode_q      <= WAIT_RISE;
      mask_q      <= '0;
      match_q     <= '0;
      occ_nb_q    <= '0;
      max_to_q    <= '0;
      elapsed_q   <= '0;
      occ_q       <= '0;
      o_busy_q    <= 1'b0;
      o_done_q    <= 1'b0;
      o_timeout_q <= 1'b0;
      o_cfg_err_q <= 1'b0;
      o_elapsed_q <= '0;
      o_occ_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      match_q     <= match_d;
      occ_nb_q    <= occ_nb_d;
      max_to_q    <= max_to_d;
      elapsed_q   <= elapsed_d;
      occ_q       <= occ_d;
      o_busy_q    <= o_busy_d;
      o_done_q    <= o_done_d;
      o_timeout_q <= o_timeout_d;
      o_cfg_err_q <= o_cfg_err_d;
      o_elapsed_q <= o_elapsed_d;
      o_occ_cnt_q <= o_occ_cnt_d;
    end
  end

  assign o_busy    = o_busy_q;
  assign o_done    = o_done_q;
  assign o_timeout = o_timeout_q;
  assign o_cfg_err = o_cfg_err_q;
  assign o_elapsed = o_elapsed_q;
  assign o_occ_cnt = o_occ_cnt_q;

endmodule

// File: tb/tb_wait_event_mon.sv
// Bench for wait_event_mon: directed vector table, hand-written corner
// sequences and random waits checked against a trace-level outcome model.
module tb_wait_event_mon;

  localparam int WS   = 5;
  localparam int WW   = 8;
  localparam int OW   = 8;
  localparam int SW   = 3;
  localparam int BW   = WS * WW;
  localparam int MAXC = 48;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_start, i_abort;
  logic [SW-1:0]  i_sel;
  logic [1:0]     i_mode;
  logic [WW-1:0]  i_mask, i_match_val;
  logic [OW-1:0]  i_occ_nb;
  logic [31:0]    i_max_timeout;
  logic [BW-1:0]  i_wait;
  logic           o_busy, o_done, o_timeout, o_cfg_err;
  logic [31:0]    o_elapsed;
  logic [OW-1:0]  o_occ_cnt;

  int checks = 0;
  int errors = 0;
  int exp_last_el = 0;
  int exp_last_occ = 0;
  logic [7:0] trace [MAXC];

  always #5 clk = ~clk;

  wait_event_mon #(.WAIT_SIZE(WS), .WAIT_WIDTH(WW), .OCC_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_sel(i_sel), .i_mode(i_mode), .i_mask(i_mask), .i_match_val(i_match_val),
    .i_occ_nb(i_occ_nb), .i_max_timeout(i_max_timeout), .i_wait(i_wait),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_cfg_err(o_cfg_err),
    .o_elapsed(o_elapsed), .o_occ_cnt(o_occ_cnt)
  );

  typedef struct {
    string       name;
    logic [2:0]  sel;
    logic [1:0]  mode;
    logic [7:0]  mask;
    logic [7:0]  match;
    logic [7:0]  occ_nb;
    logic [31:0] max_to;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [63:0] bits;
    int          exp_done;
    logic        exp_tmo;
    int          exp_el;
    int          exp_occ;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_wait(input logic [SW-1:0] sel, input logic [7:0] v);
    i_wait = BW'({$urandom(), $urandom()});
    i_wait[int'(sel)*WW +: WW] = v;
  endtask

  // Outcome predicted from the sampled channel trace: trace[1] is the ARM
  // reference, trace[2..] are evaluated; an event at cycle c ends the wait at c+1.
  function automatic void model(input logic [1:0] mode, input logic [7:0] mask,
                                input logic [7:0] match, input logic [7:0] occ_nb,
                                input int max_to, input int len,
                                output int done_c, output logic tmo,
                                output int el, output int occ);
    int need;
    int cnt;
    logic [7:0] prev;
    logic [7:0] m;
    need = (occ_nb == 8'd0) ? 1 : int'(occ_nb);
    cnt = 0;
    done_c = 0; tmo = 1'b0; el = 0; occ = 0;
    prev = trace[1] & mask;
    for (int c = 2; c < len; c++) begin
      bit hit;
      m = trace[c] & mask;
      case (mode)
        2'b00:   hit = (prev == 8'd0) && (m != 8'd0);
        2'b01:   hit = (prev != 8'd0) && (m == 8'd0);
        2'b10:   hit = (m == (match & mask));
        default: hit = (m != prev);
      endcase
      if (mode == 2'b10) cnt = hit ? cnt + 1 : 0;
      else               cnt = cnt + int'(hit);
      if (cnt >= need || (max_to != 0 && c - 1 >= max_to)) begin
        done_c = c + 1;
        tmo    = !(cnt >= need);
        el     = c - 1;
        occ    = cnt;
        return;
      end
      prev = m;
    end
  endfunction

  // exp_done == 0 means no completion is expected; the wait is aborted at cycle len.
  task automatic run_wait(input string tag, input logic [SW-1:0] sel, input logic [1:0] mode,
                          input logic [7:0] mask, input logic [7:0] match,
                          input logic [7:0] occ_nb, input logic [31:0] max_to,
                          input int len, input int exp_done, input logic exp_tmo,
                          input int exp_el, input int exp_occ);
    int ndone, first, busy_bad, err_bad, last;
    logic tmo_s;
    logic [31:0] el_s;
    logic [7:0] occ_s;
    ndone = 0; first = 0; busy_bad = 0; err_bad = 0;
    tmo_s = 1'b0; el_s = 32'd0; occ_s = 8'd0;
    last = (exp_done == 0) ? len : exp_done;
    cyc();
    i_start = 1'b1; i_abort = 1'b0; i_sel = sel; i_mode = mode; i_mask = mask;
    i_match_val = match; i_occ_nb = occ_nb; i_max_timeout = max_to;
    set_wait(sel, trace[0]);
    for (int c = 1; c <= len + 1; c++) begin
      cyc();
      i_start = (c <= last && c != len) ? 1'($urandom) : 1'b0;
      i_abort = (exp_done == 0 && c == len);
      i_sel = SW'($urandom); i_mode = 2'($urandom); i_mask = 8'($urandom);
      i_match_val = 8'($urandom); i_occ_nb = 8'($urandom); i_max_timeout = $urandom;
      set_wait(sel, trace[c]);
      smp();
      if (o_done === 1'b1) begin
        ndone++;
        if (first == 0) begin
          first = c; tmo_s = o_timeout; el_s = o_elapsed; occ_s = o_occ_cnt;
        end
      end
      if (o_busy !== (c < ((exp_done == 0) ? len + 1 : exp_done))) busy_bad++;
      if (o_cfg_err !== 1'b0) err_bad++;
    end
    i_start = 1'b0; i_abort = 1'b0;
    chk({tag, "_done_cycle"}, first, exp_done);
    chk({tag, "_done_count"}, ndone, (exp_done == 0) ? 0 : 1);
    chk({tag, "_busy_cycles_wrong"}, busy_bad, 0);
    chk({tag, "_cfg_err_cycles"}, err_bad, 0);
    if (exp_done != 0) begin
      chk({tag, "_timeout"}, 32'(tmo_s), 32'(exp_tmo));
      chk({tag, "_elapsed"}, el_s, exp_el);
      chk({tag, "_occ_cnt"}, 32'(occ_s), exp_occ);
      exp_last_el = exp_el;
      exp_last_occ = exp_occ;
    end else begin
      chk({tag, "_held_elapsed"}, o_elapsed, exp_last_el);
      chk({tag, "_held_occ_cnt"}, 32'(o_occ_cnt), exp_last_occ);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"rise3",    3'd2, 2'b00, 8'h01, 8'h00, 8'd3, 32'd0,  8'h10, 8'h11, 64'h258,              10, 1'b0, 8, 3};
    vecs[1] = '{"fall_tmo", 3'd0, 2'b01, 8'hFF, 8'h00, 8'd1, 32'd10, 8'h00, 8'h00, 64'h0,                12, 1'b1, 10, 0};
    vecs[2] = '{"match4",   3'd4, 2'b10, 8'hFF, 8'hA5, 8'd4, 32'd0,  8'hA5, 8'h00, 64'h20,               10, 1'b0, 8, 4};
    vecs[3] = '{"tie",      3'd1, 2'b00, 8'h80, 8'h00, 8'd1, 32'd5,  8'h00, 8'h80, 64'h40,               7,  1'b0, 5, 1};
    vecs[4] = '{"chg_tmo",  3'd3, 2'b11, 8'h0F, 8'h00, 8'd5, 32'd6,  8'h30, 8'hC1, 64'h08,               8,  1'b1, 6, 2};
    vecs[5] = '{"occ0",     3'd0, 2'b01, 8'h02, 8'h00, 8'd0, 32'd0,  8'h00, 8'h02, 64'h0F,               5,  1'b0, 3, 1};
    vecs[6] = '{"match_msk",3'd2, 2'b10, 8'h0F, 8'hFF, 8'd2, 32'd0,  8'h3F, 8'h07, 64'h04,               5,  1'b0, 3, 2};
    vecs[7] = '{"first_ev", 3'd1, 2'b00, 8'hFF, 8'h00, 8'd1, 32'd3,  8'h00, 8'h5A, 64'hFFFFFFFFFFFFFFFC, 3,  1'b0, 1, 1};
    vecs[8] = '{"arm_ref",  3'd1, 2'b00, 8'hFF, 8'h00, 8'd1, 32'd3,  8'h00, 8'h5A, 64'hFFFFFFFFFFFFFFFE, 5,  1'b1, 3, 0};

    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_sel = '0; i_mode = '0; i_mask = '0;
    i_match_val = '0; i_occ_nb = '0; i_max_timeout = '0; i_wait = '0;
    repeat (3) cyc();
    smp();
    chk("reset_flags", {28'd0, o_busy, o_done, o_timeout, o_cfg_err}, 32'd0);
    chk("reset_elapsed", o_elapsed, 32'd0);
    chk("reset_occ_cnt", 32'(o_occ_cnt), 32'd0);
    cyc();
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      for (int c = 0; c < MAXC; c++) trace[c] = vecs[v].bits[c] ? vecs[v].b : vecs[v].a;
      run_wait(vecs[v].name, vecs[v].sel, vecs[v].mode, vecs[v].mask, vecs[v].match,
               vecs[v].occ_nb, vecs[v].max_to, 24, vecs[v].exp_done, vecs[v].exp_tmo,
               vecs[v].exp_el, vecs[v].exp_occ);
    end

    // Abort mid-WAIT, then an out-of-range channel index.
    for (int c = 0; c < MAXC; c++) trace[c] = 8'h00;
    run_wait("abort", 3'd0, 2'b00, 8'hFF, 8'h00, 8'd1, 32'd0, 6, 0, 1'b0, 0, 0);
    cyc();
    i_start = 1'b1; i_sel = 3'd5;
    smp();
    chk("badsel_busy_pre", 32'(o_busy), 32'd0);
    cyc();
    i_start = 1'b0;
    smp();
    chk("badsel_cfg_err", 32'(o_cfg_err), 32'd1);
    chk("badsel_busy", 32'(o_busy), 32'd0);
    cyc();
    smp();
    chk("badsel_cfg_err_pulse", {30'd0, o_cfg_err, o_done}, 32'd0);

    // Start during DONE is ignored; start the cycle after DONE is accepted.
    cyc();
    i_start = 1'b1; i_sel = 3'd1; i_mode = 2'b00; i_mask = 8'hFF; i_occ_nb = 8'd1;
    i_max_timeout = 32'd0; set_wait(3'd1, 8'h00);
    cyc(); i_start = 1'b0; set_wait(3'd1, 8'h00);
    cyc(); set_wait(3'd1, 8'h01);
    cyc(); i_start = 1'b1; i_sel = 3'd7;
    smp();
    chk("b2b_done", 32'(o_done), 32'd1);
    chk("b2b_elapsed", o_elapsed, 32'd1);
    chk("b2b_occ_cnt", 32'(o_occ_cnt), 32'd1);
    exp_last_el = 1; exp_last_occ = 1;
    cyc(); i_sel = 3'd0;
    smp();
    chk("b2b_ignored_start", {30'd0, o_cfg_err, o_busy}, 32'd0);
    cyc(); i_start = 1'b0; i_abort = 1'b1;
    smp();
    chk("b2b_accepted", 32'(o_busy), 32'd1);
    cyc(); i_abort = 1'b0;
    smp();
    chk("b2b_aborted", {30'd0, o_busy, o_done}, 32'd0);

    // Reset cuts a wait on the very cycle its event arrives.
    cyc();
    i_start = 1'b1; i_sel = 3'd3; i_mode = 2'b00; i_mask = 8'hFF; i_occ_nb = 8'd1;
    i_max_timeout = 32'd0; set_wait(3'd3, 8'h00);
    cyc(); i_start = 1'b0; set_wait(3'd3, 8'h00);
    cyc(); set_wait(3'd3, 8'h00);
    cyc(); set_wait(3'd3, 8'h00);
    cyc(); set_wait(3'd3, 8'hFF); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    smp();
    chk("rst_mid_flags", {28'd0, o_busy, o_done, o_timeout, o_cfg_err}, 32'd0);
    chk("rst_mid_elapsed", o_elapsed, 32'd0);
    chk("rst_mid_occ_cnt", 32'(o_occ_cnt), 32'd0);
    exp_last_el = 0; exp_last_occ = 0;
    begin
      int late;
      late = 0;
      for (int c = 0; c < 12; c++) begin
        cyc(); set_wait(3'd3, (c % 2 == 0) ? 8'h00 : 8'hFF);
        smp();
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_timeout !== 1'b0) late++;
      end
      chk("rst_mid_no_done_after", late, 0);
    end

    // Random waits against the trace model.
    for (int t = 0; t < 30; t++) begin
      logic [2:0]  sel;
      logic [1:0]  mode;
      logic [7:0]  mask, match, occ_nb;
      logic [31:0] max_to;
      int d, el, oc;
      logic tm;
      sel    = 3'($urandom_range(0, WS - 1));
      mode   = 2'($urandom);
      mask   = 8'($urandom);
      match  = 8'($urandom);
      occ_nb = 8'($urandom_range(0, 4));
      max_to = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 35));
      for (int c = 0; c < MAXC; c++) begin
        if (c > 0 && $urandom_range(0, 2) != 0) trace[c] = trace[c-1];
        else if (mode == 2'b10 && $urandom_range(0, 1) == 1) trace[c] = match ^ (8'($urandom) & ~mask);
        else trace[c] = 8'($urandom);
      end
      model(mode, mask, match, occ_nb, int'(max_to), 40, d, tm, el, oc);
      run_wait($sformatf("rnd%0d", t), sel, mode, mask, match, occ_nb, max_to, 40, d, tm, el, oc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
